pb_counter_display: RTL

Parametrised successor to the single push-button counter plus 4-digit display pair. It debounces separate up and down buttons and keeps an up/down counter of DIGITS hex or BCD digits. It also drives a multiplexed active-low seven-segment display of DIGITS digits. It sits directly under the board top level, between the pin-level buttons and the display pins.

---
 rtl/pb_display_pkg.sv | 56 +++++
 rtl/pb_counter_display_if.sv | 9 +
 rtl/button_debouncer.sv | 46 ++++
 rtl/pb_counter_display.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pb_display_pkg.sv
// Shared constants and helpers for the push-button counter/display block:
// active-low seven-segment patterns (bit 0 = a .. bit 6 = g), counter sizing and MAX.
package pb_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int count_width(input int digits);
    return 4 * digits;
  endfunction

  // Largest counter value before wrap: 10^digits-1 (BCD) or 16^digits-1 (hex).
  function automatic longint unsigned count_max(input int digits, input bit bcd);
    longint unsigned m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * (bcd ? 10 : 16);
    return m - 1;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/pb_counter_display_if.sv
// Multiplexed seven-segment display pins: segments, decimal point, digit enables (all active-low).
interface pb_counter_display_if #(parameter int DIGITS = 4);
  logic [6:0]        seven_segment;
  logic              dp;
  logic [DIGITS-1:0] an;

  modport master (output seven_segment, output dp, output an);
  modport slave  (input  seven_segment, input  dp, input  an);
endinterface

// File: rtl/button_debouncer.sv
// 2-flop synchroniser plus stable-sample debouncer; emits a one-cycle pulse when the
// accepted level flips 0->1.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             pulse_reg;
  logic [CNT_W-1:0] stable_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      level_reg  <= 1'b0;
      pulse_reg  <= 1'b0;
      stable_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        stable_reg <= '0;
      end else if (stable_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        stable_reg <= '0;
        level_reg  <= sync2_reg;
        pulse_reg  <= sync2_reg;
      end else begin
        stable_reg <= stable_reg + 1'b1;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/pb_counter_display.sv
// Debounced up/down counter with multiplexed seven-segment output.
// Define COUNTER_BCD_EN for decimal digits; otherwise the counter is plain binary (hex display).
module pb_counter_display
  import pb_display_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             btn_up,
  input  logic                             btn_down,
  input  logic                             clear,
  output logic [count_width(DIGITS)-1:0]   count,
  pb_counter_display_if.master             disp
);

  localparam int CW    = count_width(DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              up_pulse;
  logic              down_pulse;
  logic              clr_sync1_reg;
  logic              clr_sync2_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic [CW-1:0]     count_inc;
  logic [CW-1:0]     count_dec;
  logic [PRE_W-1:0]  prescale_reg;
  logic [IDX_W-1:0]  digit_idx_reg;
  logic [DIGITS-1:0] an_reg;
  logic [6:0]        seg_reg;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .pulse (up_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_down),
    .pulse (down_pulse)
  );

`ifdef COUNTER_BCD_EN
  logic       inc_carry;
  logic       dec_borrow;
  logic [3:0] digit_val;

  // Ripple decimal carry/borrow through the digits; 9..9+1 and 0..0-1 wrap naturally.
  always_comb begin
    count_inc  = '0;
    count_dec  = '0;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    digit_val  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_val = count_reg[4*i +: 4];
      if (!inc_carry)             count_inc[4*i +: 4] = digit_val;
      else if (digit_val == 4'd9) count_inc[4*i +: 4] = 4'd0;
      else begin
        count_inc[4*i +: 4] = digit_val + 4'd1;
        inc_carry           = 1'b0;
      end
      if (!dec_borrow)            count_dec[4*i +: 4] = digit_val;
      else if (digit_val == 4'd0) count_dec[4*i +: 4] = 4'd9;
      else begin
        count_dec[4*i +: 4] = digit_val - 4'd1;
        dec_borrow          = 1'b0;
      end
    end
  end
`else
  assign count_inc = count_reg + CW'(1);
  assign count_dec = count_reg - CW'(1);
`endif

  always_comb begin
    count_next = count_reg;
    if (clr_sync2_reg)                count_next = '0;
    else if (up_pulse && !down_pulse) count_next = count_inc;
    else if (down_pulse && !up_pulse) count_next = count_dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_sync1_reg <= 1'b0;
      clr_sync2_reg <= 1'b0;
      count_reg     <= '0;
    end else begin
      clr_sync1_reg <= clear;
      clr_sync2_reg <= clr_sync1_reg;
      count_reg     <= count_next;
    end
  end

  // Scan: an/segments follow the digit index one cycle later so they always agree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_reg  <= '0;
      digit_idx_reg <= '0;
      an_reg        <= {{(DIGITS-1){1'b1}}, 1'b0};
      seg_reg       <= SEG_0;
    end else begin
      if (prescale_reg == PRE_W'(SCAN_DIV - 1)) begin
        prescale_reg  <= '0;
        digit_idx_reg <= (digit_idx_reg == IDX_W'(DIGITS - 1)) ? '0 : digit_idx_reg + 1'b1;
      end else begin
        prescale_reg <= prescale_reg + 1'b1;
      end
      an_reg  <= ~(DIGITS'(1) << digit_idx_reg);
      seg_reg <= seg_decode(count_reg[{digit_idx_reg, 2'b00} +: 4]);
    end
  end

  assign count              = count_reg;
  assign disp.an            = an_reg;
  assign disp.seven_segment = seg_reg;
  assign disp.dp            = 1'b1;

endmodule
